// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types for the HI/LO result-path sequencer.
// Holds the FSM state encoding, the HI/LO source-select codes and the op decode.
package hilo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULT_RUN = 2'd1,
      DIV_RUN  = 2'd2,
      WRITE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_MULT = 2'd1,
      OP_DIV  = 2'd2,
      OP_DIVZ = 2'd3
   } op_t;

   localparam logic SEL_MULT = 1'b0;
   localparam logic SEL_DIV  = 1'b1;

   // Classify an issue request; a zero divisor is trapped here so the
   // divider is never started on it.
   function automatic op_t decode_op(
      input logic        start,
      input logic        is_div,
      input logic [31:0] divisor
   );
      op_t op;
      op = OP_NONE;
      unique case (1'b1)
         !start:
            op = OP_NONE;
         start && !is_div:
            op = OP_MULT;
         start && is_div && (divisor == '0):
            op = OP_DIVZ;
         default:
            op = OP_DIV;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/hilo_watchdog.sv
// hilo_watchdog: run-length counter for the HI/LO sequencer.
// Ports: clk, reset (async, active-low), clr, en, expired (last allowed cycle).
module hilo_watchdog
   import hilo_pkg::*;
#(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   // cnt holds the number of completed RUN cycles, so it equals LIMIT-1
   // during the LIMIT-th RUN cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences MULT/DIV through the iterative units into HI/LO.
// Build option HILO_TIMEOUT_EN adds the RUN-state watchdog.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_is_div,
  input  logic [31:0] divisor,
  output logic        mult_start,
  input  logic        mult_done,
  output logic        div_start,
  input  logic        div_done,
  output logic        hilo_sel,
  output logic        hi_we,
  output logic        lo_we,
  output logic        busy,
  input  logic        mf_req,
  output logic        mf_stall,
  output logic        div_zero_exc,
  output logic        timeout_exc
);

  state_t state;
  op_t    op;
  logic   unit_done;
  logic   wd_expired;

  assign op = decode_op(op_start, op_is_div, divisor);

  assign unit_done = ((state == MULT_RUN) && mult_done)
                  || ((state == DIV_RUN) && div_done);

`ifdef HILO_TIMEOUT_EN
  logic in_run;
  logic to_q;

  assign in_run = (state == MULT_RUN) || (state == DIV_RUN);

  hilo_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_run),
    .en      (in_run),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_q <= 1'b0;
    end else begin
      to_q <= in_run && !unit_done && wd_expired;
    end
  end

  assign timeout_exc = to_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_exc = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hilo_sel     <= SEL_MULT;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_we        <= 1'b0;
      lo_we        <= 1'b0;
      busy         <= 1'b0;
      div_zero_exc <= 1'b0;
    end else begin
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_we        <= 1'b0;
      lo_we        <= 1'b0;
      div_zero_exc <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (op)
            OP_MULT: begin
              state      <= MULT_RUN;
              hilo_sel   <= SEL_MULT;
              mult_start <= 1'b1;
              busy       <= 1'b1;
            end
            OP_DIV: begin
              state     <= DIV_RUN;
              hilo_sel  <= SEL_DIV;
              div_start <= 1'b1;
              busy      <= 1'b1;
            end
            OP_DIVZ: begin
              div_zero_exc <= 1'b1;
            end
            default: begin
            end
          endcase
        end
        MULT_RUN, DIV_RUN: begin
          if (unit_done) begin
            state <= WRITE;
            hi_we <= 1'b1;
            lo_we <= 1'b1;
          end else if (wd_expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mf_stall = mf_req && busy;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: scoreboard bench for hilo_ctrl.
// Stimulus queues expected events; a negedge monitor checks.
`timescale 1ns/1ps
module tb_hilo_ctrl;

  localparam int TO = 8;
`ifdef HILO_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  typedef enum int {
    EV_MSTART, EV_DSTART, EV_WRITE, EV_DZ, EV_TO
  } ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       cyc;
    logic     sel;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_start = 1'b0;
  logic        op_is_div = 1'b0;
  logic [31:0] divisor = '0;
  logic        mult_done = 1'b0;
  logic        div_done = 1'b0;
  logic        mf_req = 1'b0;
  logic        mult_start, div_start, hilo_sel;
  logic        hi_we, lo_we, busy, mf_stall;
  logic        div_zero_exc, timeout_exc;

  ev_t  exp_q[$];
  bit   exp_busy[int];
  logic exp_sel_from[int];
  logic model_sel = 1'b0;
  logic cur_sel = 1'b0;
  bit   eb;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  hilo_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_is_div    (op_is_div),
    .divisor      (divisor),
    .mult_start   (mult_start),
    .mult_done    (mult_done),
    .div_start    (div_start),
    .div_done     (div_done),
    .hilo_sel     (hilo_sel),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .busy         (busy),
    .mf_req       (mf_req),
    .mf_stall     (mf_stall),
    .div_zero_exc (div_zero_exc),
    .timeout_exc  (timeout_exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %s at cycle %0d, required none",
               k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.sel !== hilo_sel) begin
        n_bad++;
        $display("FAIL event: got %s cyc %0d sel %b, required %s cyc %0d sel %b",
                 k.name(), cyc, hilo_sel, e.kind.name(), e.cyc, e.sel);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_sel_from.exists(cyc)) cur_sel = exp_sel_from[cyc];
    eb = exp_busy.exists(cyc);
    n_cmp++;
    if (busy !== eb || mf_stall !== (mf_req & eb) || hilo_sel !== cur_sel) begin
      n_bad++;
      $display("FAIL level cyc %0d: busy %b stall %b sel %b, required %b %b %b",
               cyc, busy, mf_stall, hilo_sel, eb, mf_req & eb, cur_sel);
    end
    if (mult_start !== 1'b0) check_ev(EV_MSTART);
    if (div_start !== 1'b0) check_ev(EV_DSTART);
    if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
      check_ev(EV_WRITE);
      n_cmp++;
      if (hi_we !== lo_we) begin
        n_bad++;
        $display("FAIL we_pair cyc %0d: hi_we %b lo_we %b, required equal",
                 cyc, hi_we, lo_we);
      end
    end
    if (div_zero_exc !== 1'b0) check_ev(EV_DZ);
    if (timeout_exc !== 1'b0) check_ev(EV_TO);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    op_start  = 1'b0;
    op_is_div = 1'b0;
    divisor   = '0;
    mult_done = 1'b0;
    div_done  = 1'b0;
  endtask

  task automatic idle(input int n, input bit mf_hold);
    for (int i = 0; i < n; i++) begin
      op_start  = 1'b0;
      mult_done = 1'($urandom_range(0, 1));
      div_done  = 1'($urandom_range(0, 1));
      mf_req    = mf_hold | 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
  endtask

  task automatic spurious_issue();
    op_start  = ($urandom_range(0, 3) == 0);
    op_is_div = 1'($urandom_range(0, 1));
    divisor   = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
  endtask

  task automatic run_op(input bit is_div, input logic [31:0] dv,
                        input int lat, input bit mf_hold);
    int   c;
    int   run_len;
    bit   timed;
    logic nsel;
    c = cyc;
    op_start  = 1'b1;
    op_is_div = is_div;
    divisor   = dv;
    mf_req    = mf_hold | 1'($urandom_range(0, 1));
    if (is_div && dv == 32'd0) begin
      exp_q.push_back('{kind: EV_DZ, cyc: c + 1, sel: model_sel});
      step();
      clear_inputs();
      return;
    end
    nsel = is_div;
    model_sel = nsel;
    exp_sel_from[c + 1] = nsel;
    exp_q.push_back('{kind: is_div ? EV_DSTART : EV_MSTART,
                      cyc: c + 1, sel: nsel});
    timed   = WD_ON && (lat >= TO);
    run_len = timed ? TO : lat + 1;
    for (int i = c + 1; i <= c + run_len + (timed ? 0 : 1); i++)
      exp_busy[i] = 1'b1;
    if (timed)
      exp_q.push_back('{kind: EV_TO, cyc: c + 1 + TO, sel: nsel});
    else
      exp_q.push_back('{kind: EV_WRITE, cyc: c + lat + 2, sel: nsel});
    step();
    for (int k = 0; k < run_len; k++) begin
      spurious_issue();
      mf_req = mf_hold | 1'($urandom_range(0, 1));
      if (is_div) begin
        mult_done = 1'($urandom_range(0, 1));
        div_done  = !timed && (k == run_len - 1);
      end else begin
        div_done  = 1'($urandom_range(0, 1));
        mult_done = !timed && (k == run_len - 1);
      end
      step();
    end
    if (!timed) begin
      spurious_issue();
      mult_done = 1'($urandom_range(0, 1));
      div_done  = 1'($urandom_range(0, 1));
      mf_req    = mf_hold | 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
  endtask

  task automatic reset_mid_div();
    int c;
    c = cyc;
    op_start  = 1'b1;
    op_is_div = 1'b1;
    divisor   = 32'd5;
    model_sel = 1'b1;
    exp_sel_from[c + 1] = 1'b1;
    exp_q.push_back('{kind: EV_DSTART, cyc: c + 1, sel: 1'b1});
    exp_busy[c + 1] = 1'b1;
    exp_busy[c + 2] = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    model_sel = 1'b0;
    exp_sel_from[c + 3] = 1'b0;
    step();
    reset = 1'b1;
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    idle(2, 1'b0);
  endtask

  initial begin
    int   n_ops;
    bit   is_div;
    logic [31:0] dv;
    reset = 1'b0;
    repeat (3) step();
    mf_req = 1'b1;
    step();
    reset = 1'b1;
    idle(2, 1'b1);

    run_op(1'b0, 32'd0, 33, 1'b0);
    idle(1, 1'b0);
    run_op(1'b1, 32'd7, 32, 1'b0);
    idle(3, 1'b0);
    run_op(1'b1, 32'd0, 0, 1'b0);
    idle(2, 1'b0);
    run_op(1'b0, $urandom, 10, 1'b1);
    idle(3, 1'b1);
    run_op(1'b0, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'd9, 0, 1'b0);
    reset_mid_div();
    run_op(1'b0, 32'd0, TO + 4, 1'b0);
    idle(1, 1'b0);
    run_op(1'b1, 32'd5, TO - 1, 1'b0);
    idle(1, 1'b0);

    n_ops = 60;
    for (int i = 0; i < n_ops; i++) begin
      is_div = 1'($urandom_range(0, 1));
      dv = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(is_div, dv, $urandom_range(0, 40), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3), 1'b0);
    end

    idle(5, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected events never seen, required 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
